rv32i_alu: RTL and testbench

- Execute-stage arithmetic/logic unit of the STARS RV32I single-issue core.
- Decodes opcode/funct3/funct7 and operates on reg1 and a second operand (reg2 or immediate, chosen by ALU_source).
- Produces the ALU result, a branch-taken flag, and load/store effective addresses.
- All outputs are registered: one-cycle latency.

---
 rtl/rv32i_alu_pkg.sv | 32 +++
 rtl/rv32i_alu_if.sv | 32 +++
 rtl/rv32i_alu_branch_cmp.sv | 34 +++
 rtl/rv32i_alu.sv | 114 +++++++++++
 tb/tb_rv32i_alu.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_alu_pkg.sv
// rv32i_alu shared constants
// opcode / funct3 encodings for the execute-stage ALU
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FUNCT7_ALT = 5;

endpackage

// File: rtl/rv32i_alu_if.sv
// rv32i_alu operand / result bundle
// master drives the decoded instruction, slave is the ALU
interface rv32i_alu_if;
  import rv32i_pkg::*;

  logic            ALU_source;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] reg1;
  logic [XLEN-1:0] reg2;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] read_address;
  logic [XLEN-1:0] write_address;
  logic [XLEN-1:0] result;
  logic            branch;

  modport master (
    output ALU_source, opcode, funct3, funct7,
    output reg1, reg2, immediate,
    input  read_address, write_address,
    input  result, branch
  );

  modport slave (
    input  ALU_source, opcode, funct3, funct7,
    input  reg1, reg2, immediate,
    output read_address, write_address,
    output result, branch
  );

endinterface

// File: rtl/rv32i_alu_branch_cmp.sv
// rv32i branch condition evaluator
// purely combinational reg1 vs reg2 under funct3
module rv32i_branch_cmp
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  // select the condition; 010/011 are not branches
  always_comb begin
    taken_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = ~lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = ~lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_alu.sv
// rv32i execute-stage ALU
// one-cycle registered result, branch and ld/st address
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  rv32i_alu_if.slave  bus
);

  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic            alt;
  logic            taken;
  logic            is_alu;
  logic            is_br;
  logic            is_ld;
  logic            is_st;
  logic            is_lui;
  logic            unused_f7;

  logic [XLEN-1:0] result_d, result_q;
  logic [XLEN-1:0] rd_addr_d, rd_addr_q;
  logic [XLEN-1:0] wr_addr_d, wr_addr_q;
  logic            branch_d, branch_q;

  assign opb   = bus.ALU_source ? bus.immediate
                                : bus.reg2;
  assign shamt = opb[4:0];
  assign alt   = bus.funct7[FUNCT7_ALT];

  assign unused_f7 = ^{bus.funct7[6],
                       bus.funct7[4:0]};

  assign is_alu = (bus.opcode == OPC_OP)
               || (bus.opcode == OPC_OPIMM);
  assign is_br  = (bus.opcode == OPC_BRANCH);
  assign is_ld  = (bus.opcode == OPC_LOAD);
  assign is_st  = (bus.opcode == OPC_STORE);
  assign is_lui = (bus.opcode == OPC_LUI);

  rv32i_branch_cmp u_cmp (
    .a_i      (bus.reg1),
    .b_i      (bus.reg2),
    .funct3_i (bus.funct3),
    .taken_o  (taken)
  );

  // decode the operation into next-state outputs
  always_comb begin
    result_d  = '0;
    rd_addr_d = '0;
    wr_addr_d = '0;
    branch_d  = 1'b0;
    unique case (1'b1)
      is_alu: begin
        unique case (bus.funct3)
          F3_ADD:
            if ((bus.opcode == OPC_OP) && alt)
              result_d = bus.reg1 - opb;
            else
              result_d = bus.reg1 + opb;
          F3_SLL:
            result_d = bus.reg1 << shamt;
          F3_SLT:
            result_d = {31'd0,
              $signed(bus.reg1) < $signed(opb)};
          F3_SLTU:
            result_d = {31'd0, bus.reg1 < opb};
          F3_XOR:
            result_d = bus.reg1 ^ opb;
          F3_SR:
            if (alt)
              result_d = $unsigned(
                $signed(bus.reg1) >>> shamt);
            else
              result_d = bus.reg1 >> shamt;
          F3_OR:
            result_d = bus.reg1 | opb;
          F3_AND:
            result_d = bus.reg1 & opb;
          default:
            result_d = '0;
        endcase
      end
      is_br:  branch_d  = taken;
      is_ld:  rd_addr_d = bus.reg1 + bus.immediate;
      is_st:  wr_addr_d = bus.reg1 + bus.immediate;
      is_lui: result_d  = bus.immediate;
      default: ;
    endcase
  end

  // capture outputs; reset clears them at once
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      result_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      branch_q  <= 1'b0;
    end else begin
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      branch_q  <= branch_d;
    end
  end

  assign bus.result        = result_q;
  assign bus.read_address  = rd_addr_q;
  assign bus.write_address = wr_addr_q;
  assign bus.branch        = branch_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// rv32i_alu bench
// directed table plus random vectors vs a reference model
module tb_rv32i_alu;
  import rv32i_pkg::*;

  logic clk;
  logic nrst;

  rv32i_alu_if bus ();

  rv32i_alu dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        src;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] res;
    logic [31:0] ra;
    logic [31:0] wa;
    logic        br;
  } vec_t;

  vec_t tbl[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic vec_t mk(
      input string nm, input logic src,
      input logic [6:0] opc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] imm,
      input logic [31:0] res, input logic [31:0] ra,
      input logic [31:0] wa, input logic br);
    vec_t v;
    v.name = nm; v.src = src; v.opc = opc;
    v.f3 = f3; v.f7 = f7; v.r1 = r1; v.r2 = r2;
    v.imm = imm; v.res = res; v.ra = ra;
    v.wa = wa; v.br = br;
    return v;
  endfunction

  // reference: plain arithmetic from the ISA rules
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    logic [31:0] b;
    int unsigned sh;
    b  = v.src ? v.imm : v.r2;
    sh = b % 32;
    o.res = 0; o.ra = 0; o.wa = 0; o.br = 0;
    if (v.opc == 7'b0110011 || v.opc == 7'b0010011) begin
      case (v.f3)
        0: o.res = (v.opc == 7'b0110011 && v.f7[5])
                   ? v.r1 - b : v.r1 + b;
        1: o.res = v.r1 << sh;
        2: o.res = ($signed(v.r1) < $signed(b)) ? 1 : 0;
        3: o.res = (v.r1 < b) ? 1 : 0;
        4: o.res = v.r1 ^ b;
        5: o.res = v.f7[5]
                   ? 32'($signed(v.r1) >>> sh)
                   : v.r1 >> sh;
        6: o.res = v.r1 | b;
        default: o.res = v.r1 & b;
      endcase
    end else if (v.opc == 7'b1100011) begin
      case (v.f3)
        0: o.br = (v.r1 == v.r2);
        1: o.br = (v.r1 != v.r2);
        4: o.br = ($signed(v.r1) < $signed(v.r2));
        5: o.br = ($signed(v.r1) >= $signed(v.r2));
        6: o.br = (v.r1 < v.r2);
        7: o.br = (v.r1 >= v.r2);
        default: o.br = 0;
      endcase
    end else if (v.opc == 7'b0000011) begin
      o.ra = v.r1 + v.imm;
    end else if (v.opc == 7'b0100011) begin
      o.wa = v.r1 + v.imm;
    end else if (v.opc == 7'b0110111) begin
      o.res = v.imm;
    end
    return o;
  endfunction

  task automatic drive(input vec_t v);
    bus.ALU_source = v.src;
    bus.opcode     = v.opc;
    bus.funct3     = v.f3;
    bus.funct7     = v.f7;
    bus.reg1       = v.r1;
    bus.reg2       = v.r2;
    bus.immediate  = v.imm;
  endtask

  task automatic check_all(input vec_t v);
    chk({v.name, ".res"}, bus.result, v.res);
    chk({v.name, ".ra"}, bus.read_address, v.ra);
    chk({v.name, ".wa"}, bus.write_address, v.wa);
    chk({v.name, ".br"}, {31'd0, bus.branch},
        {31'd0, v.br});
  endtask

  task automatic run(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check_all(v);
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    logic [6:0] opcs [7];
    opcs = '{7'b0110011, 7'b0010011, 7'b1100011,
             7'b0000011, 7'b0100011, 7'b0110111,
             7'b1111111};
    v.name = "rnd";
    v.src  = 1'($urandom);
    v.opc  = opcs[$urandom_range(0, 6)];
    if ($urandom_range(0, 9) == 0)
      v.opc = 7'($urandom);
    v.f3   = 3'($urandom);
    v.f7   = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    v.r1   = $urandom;
    v.r2   = ($urandom_range(0, 3) == 0) ? v.r1
           : (($urandom_range(0, 2) == 0)
              ? 32'($urandom_range(0, 40)) : $urandom);
    v.imm  = ($urandom_range(0, 1) == 0)
           ? 32'($urandom_range(0, 40)) : $urandom;
    return model(v);
  endfunction

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] LU  = 7'b0110111;

  initial begin
    vec_t v;
    tbl.push_back(mk("add",  0, OP, 0, 0, 5, 7, 0, 12, 0, 0, 0));
    tbl.push_back(mk("sub",  0, OP, 0, 7'h20, 3, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk("addiw", 1, OPI, 0, 0, 32'hFFFFFFFF, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk("addi7", 1, OPI, 0, 7'h20, 10, 0, 3, 13, 0, 0, 0));
    tbl.push_back(mk("xor",  0, OP, 4, 0, 32'hF0F0, 32'h0FF0, 0, 32'hFF00, 0, 0, 0));
    tbl.push_back(mk("or",   0, OP, 6, 0, 32'hF0, 32'h0F, 0, 32'hFF, 0, 0, 0));
    tbl.push_back(mk("andi", 1, OPI, 7, 0, 32'hFF, 0, 32'h0F, 32'h0F, 0, 0, 0));
    tbl.push_back(mk("sll16", 0, OP, 1, 0, 1, 16, 0, 32'h00010000, 0, 0, 0));
    tbl.push_back(mk("sll32", 0, OP, 1, 0, 1, 32, 0, 1, 0, 0, 0));
    tbl.push_back(mk("srl",  0, OP, 5, 0, 32'h80000000, 1, 0, 32'h40000000, 0, 0, 0));
    tbl.push_back(mk("sra",  0, OP, 5, 7'h20, 32'h80000000, 1, 0, 32'hC0000000, 0, 0, 0));
    tbl.push_back(mk("srli", 1, OPI, 5, 0, 32'h10000, 0, 16, 1, 0, 0, 0));
    tbl.push_back(mk("slt",  0, OP, 2, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("sltu", 0, OP, 3, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("beq1", 0, BR, 0, 0, 5, 5, 0, 0, 0, 0, 1));
    tbl.push_back(mk("beq0", 0, BR, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk("beqim", 1, BR, 0, 0, 5, 5, 9, 0, 0, 0, 1));
    tbl.push_back(mk("bne",  0, BR, 1, 0, 5, 6, 0, 0, 0, 0, 1));
    tbl.push_back(mk("blt",  0, BR, 4, 0, 32'hFFFFFFFE, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("bge",  0, BR, 5, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 1));
    tbl.push_back(mk("bltu", 0, BR, 6, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 1));
    tbl.push_back(mk("bgeu", 0, BR, 7, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
    tbl.push_back(mk("br010", 0, BR, 2, 0, 5, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load", 1, LD, 2, 0, 32'h1000, 0, 32'hFFFFFFFC, 0, 32'h0FFC, 0, 0));
    tbl.push_back(mk("store", 1, ST, 2, 0, 32'h2000, 0, 8, 0, 0, 32'h2008, 0));
    tbl.push_back(mk("lui",  1, LU, 0, 0, 7, 0, 32'h12345000, 32'h12345000, 0, 0, 0));
    tbl.push_back(mk("bad",  1, 7'b1111111, 0, 0, 7, 9, 3, 0, 0, 0, 0));

    // held reset with arbitrary inputs
    nrst = 1'b0;
    drive(mk("x", 1, OP, 0, 0, 32'hDEAD, 32'hBEEF, 32'h55, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check_all(mk("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // release and first op
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_hold", bus.result, 32'd0);
    run(mk("first", 0, OP, 0, 0, 1, 0, 0, 1, 0, 0, 0));

    foreach (tbl[i]) run(tbl[i]);

    // async reset mid-cycle discards in-flight op
    run(mk("pre", 1, LD, 0, 0, 32'h40, 0, 4, 0, 32'h44, 0, 0));
    drive(mk("x", 0, OP, 0, 0, 9, 9, 0, 0, 0, 0, 0));
    #2;
    nrst = 1'b0;
    #1;
    check_all(mk("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("arst_edge", bus.result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    run(mk("post", 0, OP, 0, 0, 2, 3, 0, 5, 0, 0, 0));

    // back-to-back random vectors
    for (int k = 0; k < 400; k++) begin
      v = rnd_vec();
      run(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
